// File: rtl/fifo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifo_pkg
// Brief    : Shared defaults and width helpers for the fifo_stream slice.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int c_default_data_width = 32;
    localparam int c_default_depth      = 4;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy spans 0..DEPTH+1 once the optional output register is counted.
    function automatic int count_width(input int depth);
        return ptr_width(depth) + 2;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_out_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifo_out_stage
// Brief    : Single-entry valid/ready output register for the FIFO read side.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module fifo_out_stage
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_load;

    assign in_ready  = !r_valid || out_ready;
    assign w_load    = in_valid && in_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Flush drops the valid flag only; the held word is simply ignored.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule : fifo_out_stage
`default_nettype wire

// File: rtl/fifo_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifo_stream
// Brief    : Synchronous valid/ready FIFO, FWFT or registered-output read side.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module fifo_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = c_default_data_width,
    parameter int DEPTH        = c_default_depth,
    parameter int FWFT         = 1,
    parameter int AFULL_LEVEL  = DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          flush,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          almost_full,
    output logic                          almost_empty
);

    localparam int                 c_ptr_w    = ptr_width(DEPTH);
    localparam int                 c_cnt_w    = count_width(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_mem_full = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w:0]   c_mem_one  = (c_ptr_w + 1)'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w:0]      r_mem_cnt;
    logic [c_cnt_w-1:0]    r_count;
    logic                  w_mem_valid;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_pop;

    assign w_mem_valid  = (r_mem_cnt != '0);
    assign s_ready      = (r_mem_cnt < c_mem_full);
    assign w_wr         = s_valid && s_ready;
    assign w_rd         = m_valid && m_ready;
    assign count        = r_count;
    assign almost_full  = (int'(r_count) >= AFULL_LEVEL);
    assign almost_empty = (int'(r_count) <= AEMPTY_LEVEL);

    generate
        if (FWFT != 0) begin : g_fwft
            assign m_valid = w_mem_valid;
            assign m_data  = r_mem[r_rd_ptr];
            assign w_pop   = w_rd;
        end else begin : g_out_reg
            logic w_stage_ready;

            fifo_out_stage #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_out_stage (
                .clk       (clk),
                .clr       (clr),
                .flush     (flush),
                .in_valid  (w_mem_valid),
                .in_ready  (w_stage_ready),
                .in_data   (r_mem[r_rd_ptr]),
                .out_valid (m_valid),
                .out_ready (m_ready),
                .out_data  (m_data)
            );

            assign w_pop = w_mem_valid && w_stage_ready;
        end
    endgenerate

    // Storage is never cleared; pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (clr && !flush && w_wr) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr || flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr, w_pop})
                2'b10:   r_mem_cnt <= r_mem_cnt + c_mem_one;
                2'b01:   r_mem_cnt <= r_mem_cnt - c_mem_one;
                default: r_mem_cnt <= r_mem_cnt;
            endcase
        end
    end

    // Total occupancy moves only on external transfers; the internal
    // memory-to-output-register hop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!clr || flush) begin
            r_count <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : fifo_stream
`default_nettype wire
